// File: rtl/i2s_tx_if.sv
// Sample-pair handshake between an audio source and the i2s_tx serializer.
interface i2s_tx_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic signed [SAMPLE_WIDTH-1:0] left_sample;
    logic signed [SAMPLE_WIDTH-1:0] right_sample;
    logic                           sample_valid;
    logic                           sample_ready;

    modport master (
        output left_sample,
        output right_sample,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  left_sample,
        input  right_sample,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_tx.sv
// I2S stereo transmitter: one holding register feeding a 2*SAMPLE_WIDTH frame shifter.
// Define I2S_TX_REPEAT_EN to replay the last loaded pair on underrun instead of silence.
module i2s_tx #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int BCLK_HALF    = 6
) (
    input  logic    audio_clock,
    input  logic    reset_n,
    i2s_tx_if.slave smp,
    output logic    aud_bclk,
    output logic    aud_daclrck,
    output logic    aud_dacdat,
    output logic    underrun
);
    localparam int FRAME_BITS = 2 * SAMPLE_WIDTH;
    localparam int SLOT_W     = $clog2(FRAME_BITS);
    localparam int DIV_W      = 8;

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(BCLK_HALF - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(FRAME_BITS - 1);
    localparam logic [SLOT_W-1:0] SLOT_RIGHT = SLOT_W'(SAMPLE_WIDTH);

    logic [DIV_W-1:0]      div_q,       div_d;
    logic                  bclk_q,      bclk_d;
    logic [SLOT_W-1:0]     slot_q,      slot_d;
    logic                  lrck_q,      lrck_d;
    logic [FRAME_BITS-1:0] shift_q,     shift_d;
    logic                  underrun_q,  underrun_d;
    logic                  hold_full_q, hold_full_d;
    logic [FRAME_BITS-1:0] hold_q,      hold_d;
`ifdef I2S_TX_REPEAT_EN
    logic [FRAME_BITS-1:0] last_q,      last_d;
`endif

    logic                  div_wrap;
    logic                  bclk_fall;
    logic                  frame_load;
    logic                  accept;
    logic [SLOT_W-1:0]     slot_next;
    logic [FRAME_BITS-1:0] underrun_word;

    assign div_wrap   = (div_q == DIV_LAST);
    assign bclk_fall  = div_wrap && bclk_q;
    assign slot_next  = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
    // Loading as slot 0 ends gives the one-bit I2S delay: left MSB lands in slot 1.
    assign frame_load = bclk_fall && (slot_q == '0);
    assign accept     = smp.sample_valid && !hold_full_q;

`ifdef I2S_TX_REPEAT_EN
    assign underrun_word = last_q;
`else
    assign underrun_word = '0;
`endif

    always_comb begin
        div_d       = div_wrap ? '0 : div_q + DIV_W'(1);
        bclk_d      = div_wrap ? ~bclk_q : bclk_q;
        slot_d      = slot_q;
        lrck_d      = lrck_q;
        shift_d     = shift_q;
        underrun_d  = 1'b0;
        hold_full_d = hold_full_q;
        hold_d      = hold_q;
`ifdef I2S_TX_REPEAT_EN
        last_d      = last_q;
`endif

        if (bclk_fall) begin
            slot_d = slot_next;
            lrck_d = (slot_next >= SLOT_RIGHT);
            if (frame_load) begin
                hold_full_d = 1'b0;
                if (hold_full_q) begin
                    shift_d = hold_q;
`ifdef I2S_TX_REPEAT_EN
                    last_d  = hold_q;
`endif
                end else begin
                    shift_d    = underrun_word;
                    underrun_d = 1'b1;
                end
            end else begin
                shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
            end
        end

        // A pair can only be accepted while empty, so this never races the load above.
        if (accept) begin
            hold_d      = {smp.left_sample, smp.right_sample};
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge audio_clock or negedge reset_n) begin
        if (!reset_n) begin
            div_q       <= '0;
            bclk_q      <= 1'b0;
            slot_q      <= '0;
            lrck_q      <= 1'b0;
            shift_q     <= '0;
            underrun_q  <= 1'b0;
            hold_full_q <= 1'b0;
            hold_q      <= '0;
`ifdef I2S_TX_REPEAT_EN
            last_q      <= '0;
`endif
        end else begin
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            slot_q      <= slot_d;
            lrck_q      <= lrck_d;
            shift_q     <= shift_d;
            underrun_q  <= underrun_d;
            hold_full_q <= hold_full_d;
            hold_q      <= hold_d;
`ifdef I2S_TX_REPEAT_EN
            last_q      <= last_d;
`endif
        end
    end

    assign smp.sample_ready = ~hold_full_q;
    assign aud_bclk         = bclk_q;
    assign aud_daclrck      = lrck_q;
    assign aud_dacdat       = shift_q[FRAME_BITS-1];
    assign underrun         = underrun_q;
endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboarded bench for i2s_tx: a cycle-count timing model predicts frame loads, a codec-side decoder checks the stream.
`timescale 1ns/1ps
module tb_i2s_tx;
    localparam int SW        = 16;
    localparam int BH        = 6;
    localparam int FB        = 2 * SW;
    localparam int BCLK_CYC  = 2 * BH;
    localparam int FRAME_CYC = BCLK_CYC * FB;
    localparam int LOAD_PH   = BCLK_CYC;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic aud_bclk, aud_daclrck, aud_dacdat, underrun;

    i2s_tx_if #(.SAMPLE_WIDTH(SW)) bus ();

    i2s_tx #(.SAMPLE_WIDTH(SW), .BCLK_HALF(BH)) dut (
        .audio_clock (clk),
        .reset_n     (rst_n),
        .smp         (bus.slave),
        .aud_bclk    (aud_bclk),
        .aud_daclrck (aud_daclrck),
        .aud_dacdat  (aud_dacdat),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: clock edges since reset release; loads happen at fixed cycle offsets.
    int            k = 0;
    bit            hold_m = 1'b0;
    bit            pre_full;
    logic [FB-1:0] hold_pair_m = '0;
    logic [FB-1:0] last_m = '0;
    bit            exp_unr = 1'b0;
    logic [FB-1:0] exp_q[$];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                k = 0; hold_m = 1'b0; last_m = '0; exp_unr = 1'b0;
                exp_q.delete();
            end else begin
                pre_full = hold_m;
                k++;
                exp_unr = 1'b0;
                if (k % FRAME_CYC == LOAD_PH) begin
                    if (pre_full) begin
                        exp_q.push_back(hold_pair_m);
                        last_m = hold_pair_m;
                    end else begin
`ifdef I2S_TX_REPEAT_EN
                        exp_q.push_back(last_m);
`else
                        exp_q.push_back('0);
`endif
                        exp_unr = 1'b1;
                    end
                    hold_m = 1'b0;
                end
                if (bus.sample_valid && !pre_full) begin
                    hold_pair_m = {bus.left_sample, bus.right_sample};
                    hold_m = 1'b1;
                end
            end
        end
    end

    // Monitor: per-cycle pin checks plus a codec-style decoder sampling data on rising bclk.
    int            rises = 0;
    bit            prev_bclk = 1'b0;
    bit            prev_dat = 1'b0;
    logic [FB-1:0] acc = '0;
    logic [FB-1:0] exp_frame;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_pins", {aud_bclk, aud_daclrck, aud_dacdat, underrun}, '0);
                check("reset_ready", bus.sample_ready, 1'b1);
                rises = 0; prev_bclk = 1'b0; prev_dat = 1'b0; acc = '0;
            end else begin
                check("bclk", aud_bclk, ((k / BH) % 2) == 1);
                check("lrck", aud_daclrck, ((k / BCLK_CYC) % FB) >= SW);
                check("ready", bus.sample_ready, !hold_m);
                check("underrun", underrun, exp_unr);
                if (aud_dacdat !== prev_dat)
                    check("dat_on_fall", (k > 0) && (k % BCLK_CYC == 0), 1'b1);
                prev_dat = aud_dacdat;
                if (aud_bclk && !prev_bclk) begin
                    acc = {acc[FB-2:0], aud_dacdat};
                    if ((rises % FB) == 0 && rises >= FB) begin
                        if (exp_q.size() == 0) begin
                            total++; bad++;
                            $display("FAIL frame_unexpected: got %0h expected none", acc);
                        end else begin
                            exp_frame = exp_q.pop_front();
                            check("frame", acc, exp_frame);
                            $display("frame %0h decoded, expected %0h", acc, exp_frame);
                        end
                    end
                    rises++;
                end
                prev_bclk = aud_bclk;
            end
        end
    end

    // Offer one pair until accepted; called at a negedge, returns at the negedge after acceptance.
    task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r, input int gap);
        int waited;
        bit ok;
        bus.sample_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.left_sample  = l;
        bus.right_sample = r;
        bus.sample_valid = 1'b1;
        waited = 0;
        ok = 1'b0;
        while (!ok && waited < 2 * FRAME_CYC) begin
            ok = bus.sample_ready;
            @(negedge clk);
            waited++;
        end
        check("accept_in_time", ok, 1'b1);
        $display("sent L=%h R=%h after %0d cycles", l, r, waited);
    endtask

    task automatic wait_phase(input int ph);
        int n = 0;
        while ((k % FRAME_CYC) != ph && n < 2 * FRAME_CYC) begin
            @(negedge clk);
            n++;
        end
        check("phase_reached", (k % FRAME_CYC) == ph, 1'b1);
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.left_sample  = '0;
        bus.right_sample = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;

        // Known pair before the first load, then back-to-back pairs with valid held high.
        send(16'hA5C3, 16'h0F01, 0);
        for (int i = 0; i < 5; i++) send(16'($urandom), 16'($urandom), 0);
        for (int i = 0; i < 4; i++) send(16'($urandom), 16'($urandom), $urandom_range(0, 300));

        // One known frame, then starve the transmitter.
        send(16'h1234, 16'h5678, 0);
        bus.sample_valid = 1'b0;
        repeat (3 * FRAME_CYC) @(negedge clk);

        // Fill the holding register, then reset in slot 20 while it is still full.
        wait_phase(30);
        send(16'($urandom), 16'($urandom), 0);
        bus.sample_valid = 1'b0;
        wait_phase(LOAD_PH + 19 * BCLK_CYC + 5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_pins", {aud_bclk, aud_daclrck, aud_dacdat, underrun}, '0);
        check("midreset_ready", bus.sample_ready, 1'b1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        repeat (2 * FRAME_CYC) @(negedge clk);

        for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), $urandom_range(0, 100));
        bus.sample_valid = 1'b0;
        repeat (2 * FRAME_CYC) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter: SAMPLE_WIDTH, default 16, bits per channel; frame is 2*SAMPLE_WIDTH bit-clock slots.
REQ-002 Parameter: BCLK_HALF, default 6, audio_clock cycles per bclk half-period; legal range 2..255.
REQ-003 audio_clock  input  1  system clock; all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 left_sample  input  SAMPLE_WIDTH  signed left channel word.
REQ-006 right_sample  input  SAMPLE_WIDTH  signed right channel word.
REQ-007 sample_valid  input  1  stereo pair present on left_sample/right_sample.
REQ-008 sample_ready  output  1  holding register empty; pair accepted when sample_valid and sample_ready are both high on a clock edge.
REQ-009 aud_bclk  output  1  serial bit clock to the codec DAC.
REQ-010 aud_daclrck  output  1  word select; 0 = left, 1 = right.
REQ-011 aud_dacdat  output  1  serial data, MSB first.
REQ-012 underrun  output  1  one-cycle pulse when a frame starts with the holding register empty.

Function
REQ-013 Divider counter counts 0..BCLK_HALF-1; aud_bclk toggles when the counter wraps; bclk period = 2*BCLK_HALF audio_clock cycles.
REQ-014 All aud_dacdat and aud_daclrck changes occur only in the audio_clock cycle in which aud_bclk falls (1->0); the codec samples on the rising edge.
REQ-015 Slot counter 0..2*SAMPLE_WIDTH-1 advances on each falling bclk edge and wraps to 0.
REQ-016 aud_daclrck = 0 for slots 0..SAMPLE_WIDTH-1 and 1 for slots SAMPLE_WIDTH..2*SAMPLE_WIDTH-1.
REQ-017 I2S one-bit delay: the left MSB is driven in slot 1; the left LSB in slot SAMPLE_WIDTH; the right MSB in slot SAMPLE_WIDTH+1; the right LSB in slot 0 of the following frame.
REQ-018 Shift register of width 2*SAMPLE_WIDTH is loaded with {left, right} from the holding register at the falling edge that begins slot 1, then shifts left one bit per falling edge; aud_dacdat = shift register MSB.
REQ-019 sample_ready = NOT hold_full, driven combinationally from the hold_full register.
REQ-020 On acceptance, the pair is captured and hold_full is set on the next edge.
REQ-021 The frame load of REQ-018 clears hold_full; sample_ready rises one cycle later.
REQ-022 Acceptance and frame load never coincide because acceptance requires hold_full = 0.
REQ-023 Holding register empty at slot-1 load: underrun pulses high for exactly one audio_clock cycle; the shifter loads the underrun value per REQ-029.
REQ-024 sample_valid held high with sample_ready low: no state change; the input is held off.

Reset
REQ-025 While reset_n = 0: aud_bclk = 0, aud_daclrck = 0, aud_dacdat = 0, underrun = 0, divider = 0, slot counter = 0, shift register = 0, hold_full = 0 (sample_ready = 1).
REQ-026 Assertion of reset mid-frame immediately forces all REQ-025 values and discards the held pair.
REQ-027 After reset_n releases, the first falling bclk edge starts slot 1 of a new frame, and the first frame load occurs there.

Configuration
REQ-028 Macro I2S_TX_REPEAT_EN defined: on underrun, the shifter reloads the last successfully loaded {left, right} pair (zero if none since reset).
REQ-029 Macro I2S_TX_REPEAT_EN undefined: on underrun, the shifter loads all zeros; the last-pair register is not implemented.

Verification
REQ-030 Reset released, BCLK_HALF=6: aud_bclk period = 12 audio_clock cycles; aud_daclrck period = 384 cycles; aud_daclrck low for 192 cycles.
REQ-031 Pair left=16'hA5C3, right=16'h0F01 accepted before first load -> slots 1..16 carry A5C3 MSB first; slots 17..31 plus next slot 0 carry 0F01; underrun = 0.
REQ-032 sample_valid held high continuously with a new pair each acceptance -> exactly one acceptance per frame; sample_ready low from capture until the slot-1 load; no pair dropped or duplicated.
REQ-033 No pair supplied after one frame of 16'h1234/16'h5678 -> underrun pulses once per frame; the serial stream carries zeros without the macro and 1234/5678 repeated with I2S_TX_REPEAT_EN.
REQ-034 reset_n pulsed low in slot 20 with hold_full = 1 -> all outputs 0 within the same cycle; sample_ready = 1; the next frame after release outputs underrun data, not the discarded pair.
